// File: rtl/adam_pause_pkg.sv
// Shared types and helpers for the pause gate.
//   pause_state_t : gate state (run, draining, paused)
//   outst_w       : width needed to hold a count of 0..n
package adam_pause_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StPaused
  } pause_state_t;

  function automatic int unsigned outst_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adam_outstanding_cnt.sv
// Up/down in-flight counter, saturating at 0 and at MaxCount.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   inc_i         : one transaction issued this cycle
//   dec_i         : one transaction retired this cycle
//   count_o       : current count
//   zero_next_o   : count will be zero after the coming edge
module adam_outstanding_cnt
  import adam_pause_pkg::*;
#(
  parameter int unsigned MaxCount = 4,
  parameter int unsigned Width    = outst_w(MaxCount)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             zero_next_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && count_q != Width'(MaxCount)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign zero_next_o = (count_d == '0);

`ifndef SYNTHESIS
  // A response with nothing in flight means the downstream broke protocol.
  retire_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec_i && count_q == '0));
`endif

endmodule

// File: rtl/adam_pause_gate.sv
// Target-side pause handshake gate. On pause_req it closes the request path,
// waits for all in-flight transactions to retire, then raises pause_ack.
// Dropping pause_req lowers the ack and reopens the path on the same edge.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   pause_req / pause_ack : four-phase pause handshake with the master
//   up_valid / up_ready   : upstream request handshake
//   dn_valid / dn_ready   : downstream request handshake
//   rsp_valid, rsp_ready  : response handshake, observed only
//   outstanding, busy     : in-flight count and its non-zero flag
//   drain_err             : sticky drain timeout flag
// Optional feature macro: ADAM_PAUSE_GATE_TIMEOUT_EN enables the drain timeout;
// without it DRAIN waits indefinitely and drain_err is tied low.
module adam_pause_gate
  import adam_pause_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          RST_PAUSED      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pause_req,
  output logic                               pause_ack,
  input  logic                               up_valid,
  output logic                               up_ready,
  output logic                               dn_valid,
  input  logic                               dn_ready,
  input  logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [outst_w(MAX_OUTSTANDING)-1:0] outstanding,
  output logic                               busy,
  output logic                               drain_err
);

  localparam int unsigned CntW = outst_w(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1) begin : g_bad_max
    $error("MAX_OUTSTANDING must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  pause_state_t state_q, state_d;
  logic         open, issue, retire, zero_next, timeout;

  assign open     = (state_q == StRun) && (outstanding < CntW'(MAX_OUTSTANDING));
  assign dn_valid = up_valid & open;
  assign up_ready = dn_ready & open;
  assign issue    = dn_valid & dn_ready;
  assign retire   = rsp_valid & rsp_ready;

  adam_outstanding_cnt #(
    .MaxCount (MAX_OUTSTANDING),
    .Width    (CntW)
  ) u_cnt (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inc_i       (issue),
    .dec_i       (retire),
    .count_o     (outstanding),
    .zero_next_o (zero_next)
  );

  assign busy = (outstanding != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (pause_req) state_d = StDrain;
      StDrain: begin
        // Abort wins over completion: ack must never rise without a live req.
        if (!pause_req)     state_d = StRun;
        else if (zero_next) state_d = StPaused;
        else if (timeout)   state_d = StPaused;
      end
      StPaused: if (!pause_req) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_PAUSED ? StPaused : StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign pause_ack = (state_q == StPaused);

`ifdef ADAM_PAUSE_GATE_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            err_q, set_err;

  assign timeout = (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
  // Timeout only counts as an error when the drain did not finish on its own.
  assign set_err = (state_q == StDrain) && pause_req && !zero_next && timeout;
  assign tmr_d   = (state_q == StDrain && state_d == StDrain) ? tmr_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_q | set_err;
    end
  end

  assign drain_err = err_q;
`else
  assign timeout   = 1'b0;
  assign drain_err = 1'b0;
`endif

endmodule

// File: tb/tb_adam_pause_gate.sv
module tb_adam_pause_gate;

  localparam int unsigned MAX = 4;
  localparam bit          RSTP = 1'b1;
  localparam int unsigned TMO = 16;
`ifdef ADAM_PAUSE_GATE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int M_RUN = 0, M_DRAIN = 1, M_PAUSED = 2;

  logic       clk = 1'b0;
  logic       rst_n, pause_req, pause_ack, up_valid, up_ready, dn_valid, dn_ready;
  logic       rsp_valid, rsp_ready, busy, drain_err;
  logic [2:0] outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: in-flight count, handshake phase, drain age, error flag.
  int m_cnt = 0;
  int m_mode = M_RUN;
  int m_drain_cyc = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  adam_pause_gate #(
    .MAX_OUTSTANDING (MAX),
    .RST_PAUSED      (RSTP),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pause_req   (pause_req),
    .pause_ack   (pause_ack),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .outstanding (outstanding),
    .busy        (busy),
    .drain_err   (drain_err)
  );

  task automatic set_in(input logic uv, input logic dr, input logic rq, input logic rv,
                        input logic rr);
    up_valid  = uv;
    dn_ready  = dr;
    pause_req = rq;
    rsp_valid = rv;
    rsp_ready = rr;
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic step();
    bit open, iss, ret;
    int nxt;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0;
      m_mode = RSTP ? M_PAUSED : M_RUN;
      m_err = 1'b0;
      m_drain_cyc = 0;
    end else begin
      open = (m_mode == M_RUN) && (m_cnt < int'(MAX));
      iss  = up_valid && dn_ready && open;
      ret  = rsp_valid && rsp_ready;
      nxt  = m_cnt + int'(iss) - int'(ret);
      if (nxt < 0) nxt = 0;
      case (m_mode)
        M_RUN: if (pause_req) begin m_mode = M_DRAIN; m_drain_cyc = 0; end
        M_DRAIN: begin
          if (!pause_req) m_mode = M_RUN;
          else if (nxt == 0) m_mode = M_PAUSED;
          else if (TMO_EN && m_drain_cyc == int'(TMO) - 1) begin
            m_mode = M_PAUSED;
            m_err = 1'b1;
          end else m_drain_cyc++;
        end
        default: if (!pause_req) m_mode = M_RUN;
      endcase
      m_cnt = nxt;
    end
    #1;
  endtask

  task automatic go_run();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 1, 1, 0, 0);
    step();
    rst_n = 1'b1;
    n_cmp += 5;
    if (pause_ack !== RSTP) begin n_bad++; $display("FAIL rst_ack: got %b want %b", pause_ack, RSTP); end
    if (up_ready !== 1'b0) begin n_bad++; $display("FAIL rst_up_ready: got %b want 0", up_ready); end
    if (outstanding !== 3'd0) begin n_bad++; $display("FAIL rst_outst: got %0d want 0", outstanding); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (drain_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", drain_err); end
    set_in(1, 1, 1, 0, 0);
    step();
    n_cmp += 2;
    if (pause_ack !== 1'b1) begin n_bad++; $display("FAIL paused_ack: got %b want 1", pause_ack); end
    if (outstanding !== 3'd0) begin n_bad++; $display("FAIL paused_no_issue: got %0d want 0", outstanding); end
    set_in(0, 1, 0, 0, 0);
    step();
    n_cmp++;
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL release_ack: got %b want 0", pause_ack); end
    set_in(1, 1, 0, 0, 0);
    #1;
    n_cmp += 2;
    if (up_ready !== 1'b1) begin n_bad++; $display("FAIL reopen_ready: got %b want 1", up_ready); end
    if (dn_valid !== 1'b1) begin n_bad++; $display("FAIL reopen_valid: got %b want 1", dn_valid); end
    step();
    n_cmp += 2;
    if (outstanding !== 3'd1) begin n_bad++; $display("FAIL first_issue: got %0d want 1", outstanding); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL first_busy: got %b want 1", busy); end
  endtask

  task automatic test_drain_wait();
    go_run();
    set_in(1, 1, 0, 0, 0);
    repeat (3) step();
    set_in(0, 1, 1, 0, 0);
    step();
    n_cmp += 3;
    if (up_ready !== 1'b0) begin n_bad++; $display("FAIL drain_closed: got %b want 0", up_ready); end
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL drain_ack: got %b want 0", pause_ack); end
    if (outstanding !== 3'd3) begin n_bad++; $display("FAIL drain_outst: got %0d want 3", outstanding); end
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 1, (i % 2 == 0), 1);
      step();
      n_cmp++;
      if (pause_ack !== (i == 4)) begin
        n_bad++;
        $display("FAIL drain_retire%0d_ack: got %b want %b", i, pause_ack, (i == 4));
      end
    end
    n_cmp++;
    if (outstanding !== 3'd0) begin n_bad++; $display("FAIL drained_outst: got %0d want 0", outstanding); end
  endtask

  task automatic test_backpressure();
    go_run();
    set_in(1, 1, 0, 0, 0);
    repeat (4) step();
    n_cmp += 3;
    if (outstanding !== 3'd4) begin n_bad++; $display("FAIL full_outst: got %0d want 4", outstanding); end
    if (up_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", up_ready); end
    if (dn_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid: got %b want 0", dn_valid); end
    step();
    n_cmp++;
    if (outstanding !== 3'd4) begin n_bad++; $display("FAIL full_hold: got %0d want 4", outstanding); end
    set_in(1, 1, 0, 1, 1);
    #1;
    n_cmp++;
    if (up_ready !== 1'b0) begin n_bad++; $display("FAIL full_retire_ready: got %b want 0", up_ready); end
    step();
    n_cmp++;
    if (outstanding !== 3'd3) begin n_bad++; $display("FAIL after_retire: got %0d want 3", outstanding); end
    #1;
    n_cmp++;
    if (up_ready !== 1'b1) begin n_bad++; $display("FAIL both_ready: got %b want 1", up_ready); end
    step();
    n_cmp++;
    if (outstanding !== 3'd3) begin n_bad++; $display("FAIL both_outst: got %0d want 3", outstanding); end
  endtask

  task automatic test_min_latency();
    go_run();
    set_in(0, 1, 1, 0, 0);
    step();
    n_cmp++;
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL lat1_ack: got %b want 0", pause_ack); end
    step();
    n_cmp++;
    if (pause_ack !== 1'b1) begin n_bad++; $display("FAIL lat2_ack: got %b want 1", pause_ack); end
    set_in(0, 1, 0, 0, 0);
    step();
    n_cmp += 2;
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL lat_release: got %b want 0", pause_ack); end
    if (up_ready !== 1'b1) begin n_bad++; $display("FAIL lat_reopen: got %b want 1", up_ready); end
  endtask

  task automatic test_abort();
    go_run();
    set_in(1, 1, 0, 0, 0);
    repeat (2) step();
    set_in(0, 1, 1, 0, 0);
    repeat (3) step();
    n_cmp += 2;
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got %b want 0", pause_ack); end
    if (up_ready !== 1'b0) begin n_bad++; $display("FAIL abort_closed: got %b want 0", up_ready); end
    set_in(1, 1, 0, 0, 0);
    step();
    n_cmp += 3;
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL aborted_ack: got %b want 0", pause_ack); end
    if (up_ready !== 1'b1) begin n_bad++; $display("FAIL aborted_open: got %b want 1", up_ready); end
    if (outstanding !== 3'd2) begin n_bad++; $display("FAIL aborted_outst: got %0d want 2", outstanding); end
  endtask

  task automatic test_reset_mid_drain();
    go_run();
    set_in(1, 1, 0, 0, 0);
    repeat (2) step();
    set_in(0, 1, 1, 0, 0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp += 3;
    if (outstanding !== 3'd0) begin n_bad++; $display("FAIL mid_rst_outst: got %0d want 0", outstanding); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (pause_ack !== RSTP) begin n_bad++; $display("FAIL mid_rst_ack: got %b want %b", pause_ack, RSTP); end
  endtask

  task automatic test_timeout();
    go_run();
    set_in(1, 1, 0, 0, 0);
    step();
    set_in(0, 1, 1, 0, 0);
    step();
    repeat (int'(TMO) - 1) step();
    n_cmp += 2;
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL tmo_early_ack: got %b want 0", pause_ack); end
    if (drain_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early_err: got %b want 0", drain_err); end
    step();
    n_cmp += 2;
    if (pause_ack !== 1'b1) begin n_bad++; $display("FAIL tmo_ack: got %b want 1", pause_ack); end
    if (drain_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b want 1", drain_err); end
    set_in(0, 1, 0, 0, 0);
    step();
    n_cmp += 2;
    if (pause_ack !== 1'b0) begin n_bad++; $display("FAIL tmo_release_ack: got %b want 0", pause_ack); end
    if (drain_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", drain_err); end
  endtask

  task automatic test_random();
    bit rq = 1'b0;
    bit open;
    go_run();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) rq = ~rq;
      set_in($urandom_range(0, 1), $urandom_range(0, 1), rq,
             (m_cnt > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0);
      #1;
      open = (m_mode == M_RUN) && (m_cnt < int'(MAX));
      n_cmp += 2;
      if (dn_valid !== (up_valid && open)) begin
        n_bad++;
        $display("FAIL rnd_dn_valid c%0d: got %b want %b", c, dn_valid, up_valid && open);
      end
      if (up_ready !== (dn_ready && open)) begin
        n_bad++;
        $display("FAIL rnd_up_ready c%0d: got %b want %b", c, up_ready, dn_ready && open);
      end
      step();
      n_cmp += 4;
      if (pause_ack !== (m_mode == M_PAUSED)) begin
        n_bad++;
        $display("FAIL rnd_ack c%0d: got %b want %b", c, pause_ack, m_mode == M_PAUSED);
      end
      if (outstanding !== 3'(m_cnt)) begin
        n_bad++;
        $display("FAIL rnd_outst c%0d: got %0d want %0d", c, outstanding, m_cnt);
      end
      if (busy !== (m_cnt != 0)) begin
        n_bad++;
        $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_cnt != 0);
      end
      if (drain_err !== m_err) begin
        n_bad++;
        $display("FAIL rnd_err c%0d: got %b want %b", c, drain_err, m_err);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_drain_wait();
    test_backpressure();
    test_min_latency();
    test_abort();
    test_reset_mid_drain();
    if (TMO_EN) test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
